// File: rtl/fir_dec_pkg.sv
// Shared defaults and sample type for the FIR decimation / output buffer stage.
package fir_dec_pkg;
    localparam int WIDTH_DEF      = 8;
    localparam int DEC_LOG2_DEF   = 2;
    localparam int DEPTH_LOG2_DEF = 3;

    typedef logic signed [WIDTH_DEF-1:0] sample_t;
endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a combinational head read and a sticky drop flag.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

    // Handshake: a word transfers on any edge where valid and ready are both high;
    // valid never depends on ready, and ready is ignored while valid is low.
    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid && ready;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign wr_en = push && (!full || pop);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fir_dec_fifo.sv
// Decimate-by-2^DEC_LOG2 stage feeding an output FIFO. Define FIR_DEC_AVG_EN for
// accumulate-and-dump averaging; otherwise the last sample of each group is picked.
module fir_dec_fifo
    import fir_dec_pkg::*;
#(
    parameter int DEC_LOG2   = DEC_LOG2_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      x_in,
    input  logic                  x_en,
    output logic [WIDTH-1:0]      y_out,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    logic [DEC_LOG2-1:0] phase;
    logic                dump;
    logic [WIDTH-1:0]    d;

    assign dump = x_en && (&phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (x_en) begin
            phase <= phase + 1'b1;
        end
    end

`ifdef FIR_DEC_AVG_EN
    localparam int AW = WIDTH + DEC_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;

    assign x_ext = {{DEC_LOG2{x_in[WIDTH-1]}}, x_in};
    assign sum   = acc + x_ext;
    // Dropping the low DEC_LOG2 bits is the floor (arithmetic) divide by M.
    assign d     = sum[AW-1:DEC_LOG2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (x_en) begin
            acc <= dump ? '0 : sum;
        end
    end
`else
    assign d = x_in;
`endif

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (dump),
        .din      (d),
        .ready    (y_ready),
        .dout     (y_out),
        .valid    (y_valid),
        .count    (count),
        .overflow (overflow)
    );
endmodule

// File: doc/fir_dec_fifo.md
# fir_dec_fifo

Decimation and output buffer stage placed directly downstream of the 4-tap FIR. It takes the FIR's 8-bit two's-complement output stream, reduces the rate by M = 2^DEC_LOG2, and stores the decimated samples in a small FIFO. Consumers drain the FIFO through a valid/ready handshake. The block decouples the full-rate filter from slower consumers and reports any lost samples.

## Interface
- DEC_LOG2, default 2: decimation factor is M = 2^DEC_LOG2; legal range is 1..4.
- DEPTH_LOG2, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8 by default).
- WIDTH, default 8: sample width in bits, two's complement.
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- x_in, input, WIDTH: FIR output sample.
- x_en, input, 1: x_in is valid this cycle; tie high when the FIR runs every clk.
- y_out, output, WIDTH: head-of-FIFO sample.
- y_valid, output, 1: FIFO is not empty.
- y_ready, input, 1: consumer accepts y_out this cycle.
- count, output, DEPTH_LOG2+1: current FIFO occupancy.
- overflow, output, 1: sticky flag; a decimated sample was dropped.

## Operation
- Phase counter `phase`, range 0..M-1, advances only on x_en and wraps from M-1 to 0.
- A dump event occurs when x_en=1 and phase=M-1. On a dump event, the decimated sample d is pushed into the FIFO on the same edge.
- When the decimated sample is the plain pick (see Configuration), d = x_in of the dump cycle.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of DEPTH_LOG2 bits, wrapping modulo depth.
  - count goes 0..2^DEPTH_LOG2.
  - y_out = mem[rd_ptr], read combinationally from the register array, so the head is visible the first cycle y_valid is high.
- Pop occurs when y_valid=1 and y_ready=1; rd_ptr advances.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Push while full:
  - With a simultaneous pop: the push is accepted.
  - Without a pop: d is discarded, wr_ptr and count are unchanged, and overflow is set to 1. overflow stays 1 until reset.
- Pop while empty cannot happen, because y_valid=0.
- y_out when empty: holds whatever mem[rd_ptr] contains. Consumers must ignore it.
- Reset values: phase=0, acc=0, rd_ptr=wr_ptr=0, count=0, y_valid=0, overflow=0, every mem entry 0, so y_out=0.
- Reset asserted mid-decimation discards the partial phase and accumulator.

## Timing
- Latency: a dump on rising edge k gives y_valid=1 and y_out=d in the cycle following edge k. There are no additional pipeline stages.
- Throughput: at most one push per M accepted inputs and at most one pop per cycle.
- x_en low cycles are ignored completely: phase and acc hold.
- y_ready may be held high permanently. y_ready may change while y_valid=0 without effect.
- overflow rises in the cycle after the dropping edge.

## Configuration
- Macro: FIR_DEC_AVG_EN.
- Defined: accumulate-and-dump averaging.
  - acc is a signed register of WIDTH+DEC_LOG2 bits, sign-extending x_in on every x_en.
  - On a dump, d = (acc + x_in) >>> DEC_LOG2, an arithmetic shift that truncates toward negative infinity. The result is the low WIDTH bits; no overflow is possible.
  - acc is cleared on the dump edge.
- Not defined: plain pick, d = x_in at phase M-1. acc is not synthesized.

## Structure
- Shared package fir_dec_pkg holds:
  - defaults for WIDTH, DEC_LOG2 and DEPTH_LOG2;
  - the sample typedef, a signed WIDTH-bit vector.
- Sub-module sync_fifo, parameterized by WIDTH and DEPTH_LOG2, contains the pointers, count, overflow and the combinational head read.
- Top level contains the phase counter, the optional accumulator, and the push generation.

## Test plan
- Reset, then x_en=1 with x_in=1,2,3,4 and y_ready=0.
  - Macro off: y_valid=1 after the 4th edge, y_out=4, count=1.
  - Macro on: y_out=2 (10>>>2).
- Macro on, x_in=0xFC repeated four times: y_out=0xFC. Then 0xFF,0x00,0x00,0x00: y_out=0xFF (sum -1 >>> 2 = -1).
- y_ready=0 with 9 dumps: count=8 after the 8th dump, overflow=1 after the 9th. Then y_ready=1 pops the first 8 samples in order, and y_valid=0 afterwards.
- Full FIFO, with a dump and y_ready=1 in the same cycle: count stays 8, overflow stays 0, and the new sample appears last.
- x_en pattern 1,0,1,0,... with a sample ramp: a dump occurs on every 4th x_en-high cycle only, and output values match the x_en-gated stream.
- reset pulsed when phase=2 with acc non-zero: all outputs return to reset values. The next dump occurs exactly 4 x_en cycles after release.
